// File: rtl/baccarat_pkg.sv
// baccarat_pkg: card codes, LFSR constants and scoring helpers shared by datapath and state machine
package baccarat_pkg;
  localparam int LFSR_W = 6;
  localparam int TAP_HI = 5;
  localparam int TAP_LO = 4;
  localparam logic [LFSR_W-1:0] LFSR_ONE = 6'b000001;
  localparam logic [3:0] CARD_EMPTY = 4'd0;
  localparam logic [3:0] CARD_ACE   = 4'd1;
  localparam logic [3:0] CARD_TEN   = 4'd10;
  localparam logic [3:0] CARD_JACK  = 4'd11;
  localparam logic [3:0] CARD_QUEEN = 4'd12;
  localparam logic [3:0] CARD_KING  = 4'd13;
  function automatic logic [3:0] card_val(input logic [3:0] c);
    return (c >= CARD_TEN) ? 4'd0 : c;
  endfunction
  function automatic logic [3:0] hand_score(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c);
    logic [4:0] s;
    s = 5'(card_val(a)) + 5'(card_val(b)) + 5'(card_val(c));
    s = (s >= 5'd20) ? s - 5'd20 : s;
    s = (s >= 5'd10) ? s - 5'd10 : s;
    return s[3:0];
  endfunction
endpackage

// File: rtl/baccarat_datapath_if.sv
// baccarat_datapath_if: load strobes, entropy and score/card outputs between state machine and datapath
interface baccarat_datapath_if;
  logic load_pcard1, load_pcard2, load_pcard3;
  logic load_dcard1, load_dcard2, load_dcard3;
  logic entropy;
  logic [3:0] pscore, dscore, pcard3;
  logic [11:0] pcards, dcards;
  modport master (
    output load_pcard1, load_pcard2, load_pcard3, load_dcard1, load_dcard2, load_dcard3, entropy,
    input  pscore, dscore, pcard3, pcards, dcards
  );
  modport slave (
    input  load_pcard1, load_pcard2, load_pcard3, load_dcard1, load_dcard2, load_dcard3, entropy,
    output pscore, dscore, pcard3, pcards, dcards
  );
endinterface

// File: rtl/card7seg.sv
// card7seg: card code to active-low gfedcba segment pattern (blank when empty)
module card7seg
  import baccarat_pkg::*;
(
  input  logic [3:0] card_i,
  output logic [6:0] seg_o
);
  always_comb begin
    seg_o = 7'b1111111;
    case (card_i)
      CARD_ACE:   seg_o = 7'b0001000;
      4'd2:       seg_o = 7'b0100100;
      4'd3:       seg_o = 7'b0110000;
      4'd4:       seg_o = 7'b0011001;
      4'd5:       seg_o = 7'b0010010;
      4'd6:       seg_o = 7'b0000010;
      4'd7:       seg_o = 7'b1111000;
      4'd8:       seg_o = 7'b0000000;
      4'd9:       seg_o = 7'b0010000;
      CARD_TEN:   seg_o = 7'b1000000;
      CARD_JACK:  seg_o = 7'b1100001;
      CARD_QUEEN: seg_o = 7'b0011000;
      CARD_KING:  seg_o = 7'b0001001;
      default:    seg_o = 7'b1111111;
    endcase
  end
endmodule

// File: rtl/baccarat_datapath.sv
// baccarat_datapath: LFSR card source, six card slots and mod-10 hand scores.
// Define BACCARAT_HEX_EN to add HEX0..HEX5 seven-segment outputs.
module baccarat_datapath
  import baccarat_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = 6'b000001
) (
  input  logic slow_clock,
  input  logic resetb,
  baccarat_datapath_if.slave bus
`ifdef BACCARAT_HEX_EN
  ,
  output logic [6:0] HEX0,
  output logic [6:0] HEX1,
  output logic [6:0] HEX2,
  output logic [6:0] HEX3,
  output logic [6:0] HEX4,
  output logic [6:0] HEX5
`endif
);
  logic [LFSR_W-1:0] lfsr_q, lfsr_d, lfsr_shift;
  logic [3:0] current_card;
  logic [2:0] pload, dload;
  logic [2:0][3:0] pcard_q, dcard_q;
  assign lfsr_shift = {lfsr_q[LFSR_W-2:0], lfsr_q[TAP_HI] ^ lfsr_q[TAP_LO] ^ bus.entropy};
  // an all-zero state would never leave, so substitute 1
  assign lfsr_d = (lfsr_shift == '0) ? LFSR_ONE : lfsr_shift;
  assign current_card = 4'(lfsr_q % 6'd13) + 4'd1;
  assign pload = {bus.load_pcard3, bus.load_pcard2, bus.load_pcard1};
  assign dload = {bus.load_dcard3, bus.load_dcard2, bus.load_dcard1};
  always_ff @(posedge slow_clock or negedge resetb) begin
    if (!resetb) begin
      lfsr_q  <= SEED;
      pcard_q <= '0;
      dcard_q <= '0;
    end else begin
      lfsr_q <= lfsr_d;
      for (int i = 0; i < 3; i++) begin
        if (pload[i]) pcard_q[i] <= current_card;
        if (dload[i]) dcard_q[i] <= current_card;
      end
    end
  end
  assign bus.pscore = hand_score(pcard_q[0], pcard_q[1], pcard_q[2]);
  assign bus.dscore = hand_score(dcard_q[0], dcard_q[1], dcard_q[2]);
  assign bus.pcard3 = pcard_q[2];
  assign bus.pcards = pcard_q;
  assign bus.dcards = dcard_q;
`ifdef BACCARAT_HEX_EN
  logic [5:0][3:0] all_cards;
  logic [5:0][6:0] hex;
  assign all_cards = {dcard_q, pcard_q};
  for (genvar g = 0; g < 6; g++) begin : g_hex
    card7seg u_seg (.card_i(all_cards[g]), .seg_o(hex[g]));
  end
  assign {HEX5, HEX4, HEX3, HEX2, HEX1, HEX0} = hex;
`endif
endmodule

// File: doc/baccarat_datapath.md
# baccarat_datapath

Card-handling datapath that sits opposite the baccarat dealing state machine. It holds a pseudo-random card source and six 4-bit card registers, three for the player and three for the dealer. Each register captures the current card when its `load_*` strobe is sampled high. The block returns the modulo-10 hand scores `pscore`/`dscore` and the player's third card `pcard3`, which the state machine uses for its drawing decisions.

## Interface
- `SEED`, default 6'b000001: LFSR value loaded on reset. Must be non-zero.
- `slow_clock` in 1: single clock; every register updates on its rising edge.
- `resetb` in 1: reset, asynchronous and active-low.
- `load_pcard1`, `load_pcard2`, `load_pcard3` in 1 each: capture the current card into player slot 1/2/3.
- `load_dcard1`, `load_dcard2`, `load_dcard3` in 1 each: capture the current card into dealer slot 1/2/3.
- `entropy` in 1: XORed into the LFSR feedback (e.g. from a player pushbutton).
- `pscore` out 4: player hand score, 0..9.
- `dscore` out 4: dealer hand score, 0..9.
- `pcard3` out 4: raw code of player card 3 (0 when empty).
- `pcards`, `dcards` out 12 each: {card3, card2, card1} codes for display or debug.

## Operation
- **Card code:** 0 = empty, 1 = Ace, 2..10 = pip, 11/12/13 = J/Q/K.
- **Card value:** 1..9 map to themselves; 0 and 10..13 map to 0.
- **Card source:** 6-bit LFSR.
  - Shift left; feedback = `lfsr[5] ^ lfsr[4] ^ entropy`; next = {`lfsr[4:0]`, feedback}.
  - Advances on every clock edge.
  - If the next value would be 0, load 6'b000001 instead, so the LFSR never locks up.
  - `current_card` = 1 + (`lfsr` mod 13), always in the range 1..13. Combinational.
- **Card registers:**
  - On an edge where `load_x` = 1, slot x takes the `current_card` value from before that edge.
  - A slot with no strobe holds its value.
  - Reloading a non-empty slot overwrites it; this is legal.
  - Several strobes high on the same edge all capture the same card. This is legal but not a case the state machine produces.
- **Scores:**
  - `pscore` = (val(p1) + val(p2) + val(p3)) mod 10.
  - Compute with a 5-bit sum (maximum 27), then reduce modulo 10 by conditional subtraction of 20 and 10.
  - `dscore` is computed the same way from the dealer slots.
  - `pscore`, `dscore` and `pcard3` are combinational from the card registers, with no extra register stage.
- **Reset (asynchronous, any time including mid-hand):**
  - All six card slots go to 0, so `pscore`, `dscore`, `pcard3`, `pcards` and `dcards` are all 0.
  - `lfsr` goes to `SEED`.
  - Outputs take their reset values immediately, without waiting for a clock edge.

## Timing
- Load latency is 1 cycle: a strobe sampled at edge n gives an updated slot, and updated scores, valid after edge n.
- The state machine therefore sees the score including card n in the state that follows the card-n load state.
- Edge numbering: edge 1 is the first rising edge after `resetb` deasserts. Before edge 1, `lfsr` = `SEED`.
- Card captured at edge k is 1 + (LFSR value before edge k) mod 13.

## Configuration
- `BACCARAT_HEX_EN` defined:
  - Adds outputs `HEX0` … `HEX5`, 7 bits each, active-low segments.
  - `HEX0`..`HEX2` show player slots 1..3; `HEX3`..`HEX5` show dealer slots 1..3.
  - Glyphs: blank for 0, A for 1, 2..9, 0 for 10, J, q, K.
- `BACCARAT_HEX_EN` not defined: HEX ports and their decoders are absent. All other behaviour is identical.

## Structure
- Shared package `baccarat_pkg` holds:
  - card code constants `CARD_EMPTY`, `CARD_ACE`, `CARD_TEN`, `CARD_JACK`, `CARD_QUEEN`, `CARD_KING`;
  - the card-value function;
  - the mod-10 score function;
  - the LFSR width and tap constants.
- The state machine imports the same package.
- One sub-module, `card7seg`: 4-bit card code in, 7-bit segment pattern out. Six instances, generated only under `BACCARAT_HEX_EN`.

## Test plan
- **Reset value:** hold `resetb` = 0 → `pscore` = 0, `dscore` = 0, `pcard3` = 0, `pcards` = 0, `dcards` = 0. Release with `entropy` = 0 → LFSR sequence 1, 2, 4, 8, 16, 33, 3.
- **Four-card deal:** strobes `load_pcard1`@edge1, `load_dcard1`@2, `load_pcard2`@3, `load_dcard2`@4 → cards 2, 3, 5, 9 → `pscore` = 7, `dscore` = 2.
- **Third cards:** continue with `load_pcard3`@5 (card 4) and `load_dcard3`@6 (card 8) → `pcard3` = 4, `pscore` = 1, `dscore` = 0.
- **Face-card value:** force slots to K, Q, 10 → score 0. Force A, 9, 9 → score 9, with a sum of 19 wrapping correctly.
- **Async reset mid-hand:** assert `resetb` low between edges while cards are held → all outputs 0 before the next edge. After release, the LFSR restarts from `SEED`.
- **LFSR lock-up guard:** drive `entropy` so that the next value would be 0 → `lfsr` becomes 1 and `current_card` stays within 1..13. Under `BACCARAT_HEX_EN`, an empty slot displays blank (7'b1111111).
